// File: rtl/multicycle_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_pkg
// Shared definitions for the multi-cycle control unit and the ALU control:
//   - stateT     : 4-bit state encoding (FETCH=0 ... TRAP=11), also exposed on
//                  the debug state port
//   - OP_*       : RV32I-subset opcode values recognised in DECODE
//   - ALU_*      : alu_op encodings consumed by the ALU control
//   - SRCB_*     : ALU B-operand select encodings
//   - PCSRC_*    : PC source select encodings
//   - ctrlT      : bundle of every datapath select/strobe driven by the unit
//   - retires()  : tells whether a state/handshake pair completes an instruction
// ---------------------------------------------------------------------------
package multicycle_pkg;

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_EXEC_R = 4'd2,
      S_EXEC_I = 4'd3,
      S_ADDR   = 4'd4,
      S_MEM_RD = 4'd5,
      S_MEM_WR = 4'd6,
      S_WB_ALU = 4'd7,
      S_WB_MEM = 4'd8,
      S_BRANCH = 4'd9,
      S_JUMP   = 4'd10,
      S_TRAP   = 4'd11
   } stateT;

   localparam logic [6:0] OP_R = 7'b0110011;
   localparam logic [6:0] OP_I = 7'b0010011;
   localparam logic [6:0] OP_L = 7'b0000011;
   localparam logic [6:0] OP_S = 7'b0100011;
   localparam logic [6:0] OP_B = 7'b1100011;
   localparam logic [6:0] OP_J = 7'b1101111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_R   = 3'b001;
   localparam logic [2:0] ALU_I   = 3'b010;
   localparam logic [2:0] ALU_S   = 3'b011;
   localparam logic [2:0] ALU_L   = 3'b100;
   localparam logic [2:0] ALU_J   = 3'b101;
   localparam logic [2:0] ALU_B   = 3'b110;

   localparam logic [1:0] SRCB_RS2  = 2'b00;
   localparam logic [1:0] SRCB_FOUR = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_TARGET = 2'b01;

   typedef struct packed {
      logic       pcWrite;
      logic       irWrite;
      logic       iord;
      logic       memRead;
      logic       memWrite;
      logic       regWrite;
      logic       memToReg;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [2:0] aluOp;
      logic [1:0] pcSrc;
      logic       ctrlR;
      logic       illegal;
   } ctrlT;

   // An instruction retires when it leaves its last state towards FETCH.
   // A store only leaves MEM_WR once memory acknowledges the write.
   function automatic logic retires(input stateT s, input logic memReady);
      case (s)
         S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP: return 1'b1;
         S_MEM_WR:                             return memReady;
         default:                              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/multicycle_outdec.sv
// ---------------------------------------------------------------------------
// multicycle_outdec
// Purely combinational state-to-strobe decoder for the multi-cycle control
// unit (Moore outputs, with the FETCH/BRANCH write strobes qualified by the
// memory handshake and the branch compare).
// Ports:
//   state     in  current FSM state
//   opcode    in  IR[6:0], selects load vs store ALU control in ADDR
//   zero      in  ALU compare result, gates pcWrite in BRANCH
//   memReady  in  memory handshake, gates irWrite/pcWrite in FETCH
//   reset     in  synchronous reset, forces every strobe low while high
//   ctrl      out bundle of datapath selects and strobes
// ---------------------------------------------------------------------------
module multicycle_outdec
   import multicycle_pkg::*;
(
   input  stateT      state,
   input  logic [6:0] opcode,
   input  logic       zero,
   input  logic       memReady,
   input  logic       reset,
   output ctrlT       ctrl
);

   // Every field starts at zero so each state only lists the strobes it
   // raises. The reset gate keeps the datapath quiet during the reset cycle
   // even though the state register only clears on the next edge.
   always_comb begin
      ctrl = '0;
      if (!reset) begin
         case (state)
            S_FETCH: begin
               ctrl.memRead = 1'b1;
               ctrl.aluSrcB = SRCB_FOUR;
               ctrl.irWrite = memReady;
               ctrl.pcWrite = memReady;
            end
            S_DECODE: begin
               ctrl.aluSrcB = SRCB_IMM;
            end
            S_EXEC_R: begin
               ctrl.aluSrcA = 1'b1;
               ctrl.aluSrcB = SRCB_RS2;
               ctrl.aluOp   = ALU_R;
               ctrl.ctrlR   = 1'b1;
            end
            S_EXEC_I: begin
               ctrl.aluSrcA = 1'b1;
               ctrl.aluSrcB = SRCB_IMM;
               ctrl.aluOp   = ALU_I;
            end
            S_ADDR: begin
               ctrl.aluSrcA = 1'b1;
               ctrl.aluSrcB = SRCB_IMM;
               ctrl.aluOp   = (opcode == OP_S) ? ALU_S : ALU_L;
            end
            S_MEM_RD: begin
               ctrl.memRead = 1'b1;
               ctrl.iord    = 1'b1;
            end
            S_MEM_WR: begin
               ctrl.memWrite = 1'b1;
               ctrl.iord     = 1'b1;
            end
            S_WB_ALU: begin
               ctrl.regWrite = 1'b1;
            end
            S_WB_MEM: begin
               ctrl.regWrite = 1'b1;
               ctrl.memToReg = 1'b1;
            end
            S_BRANCH: begin
               ctrl.aluSrcA = 1'b1;
               ctrl.aluSrcB = SRCB_RS2;
               ctrl.aluOp   = ALU_B;
               ctrl.pcSrc   = PCSRC_TARGET;
               ctrl.pcWrite = zero;
            end
            S_JUMP: begin
               ctrl.pcSrc   = PCSRC_TARGET;
               ctrl.pcWrite = 1'b1;
               ctrl.aluOp   = ALU_J;
            end
            S_TRAP: begin
               ctrl.illegal = 1'b1;
            end
            default: begin
               ctrl = '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Moore control unit sequencing one RV32I-subset instruction over 3-5 cycles
// (plus memory wait cycles) on a shared datapath. Holds the state register,
// the next-state logic and the retired-instruction counter; strobes come
// from multicycle_outdec.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   opcode_i                IR[6:0]
//   zero_i                  ALU branch compare
//   mem_ready_i             memory access completes this cycle
//   pc_write_o .. ctrl_r_o  datapath selects and strobes
//   illegal_o               sticky illegal-opcode trap flag
//   state_o                 debug view of the state encoding
//   retired_o               count of completed instructions (wraps)
// ---------------------------------------------------------------------------
module multicycle_ctrl
   import multicycle_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [6:0]       opcode_i,
   input  logic             zero_i,
   input  logic             mem_ready_i,
   output logic             pc_write_o,
   output logic             ir_write_o,
   output logic             iord_o,
   output logic             mem_read_o,
   output logic             mem_write_o,
   output logic             reg_write_o,
   output logic             mem_to_reg_o,
   output logic             alu_src_a_o,
   output logic [1:0]       alu_src_b_o,
   output logic [2:0]       alu_op_o,
   output logic [1:0]       pc_src_o,
   output logic             ctrl_r_o,
   output logic             illegal_o,
   output logic [3:0]       state_o,
   output logic [CNT_W-1:0] retired_o
);

   stateT            stateReg;
   logic [CNT_W-1:0] retiredReg;
   ctrlT             ctrl;

   // State register, next-state logic and retire counter in one block.
   // Reset wins over every transition and over a retire in the same cycle,
   // so an instruction aborted by reset never counts. TRAP only leaves
   // through reset; memory states hold until the handshake arrives.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stateReg   <= S_FETCH;
         retiredReg <= '0;
      end else begin
         if (retires(stateReg, mem_ready_i)) begin
            retiredReg <= retiredReg + CNT_W'(1);
         end
         case (stateReg)
            S_FETCH:  stateReg <= mem_ready_i ? S_DECODE : S_FETCH;
            S_DECODE: begin
               case (opcode_i)
                  OP_R:       stateReg <= S_EXEC_R;
                  OP_I:       stateReg <= S_EXEC_I;
                  OP_L, OP_S: stateReg <= S_ADDR;
                  OP_B:       stateReg <= S_BRANCH;
                  OP_J:       stateReg <= S_JUMP;
                  default:    stateReg <= S_TRAP;
               endcase
            end
            S_EXEC_R: stateReg <= S_WB_ALU;
            S_EXEC_I: stateReg <= S_WB_ALU;
            S_ADDR:   stateReg <= (opcode_i == OP_S) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: stateReg <= mem_ready_i ? S_WB_MEM : S_MEM_RD;
            S_MEM_WR: stateReg <= mem_ready_i ? S_FETCH : S_MEM_WR;
            S_WB_ALU: stateReg <= S_FETCH;
            S_WB_MEM: stateReg <= S_FETCH;
            S_BRANCH: stateReg <= S_FETCH;
            S_JUMP:   stateReg <= S_FETCH;
            S_TRAP:   stateReg <= S_TRAP;
            default:  stateReg <= S_FETCH;
         endcase
      end
   end

   multicycle_outdec outdec (
      .state    (stateReg),
      .opcode   (opcode_i),
      .zero     (zero_i),
      .memReady (mem_ready_i),
      .reset    (rst_i),
      .ctrl     (ctrl)
   );

   // Flatten the strobe bundle onto the ports. During reset the debug state
   // already reads FETCH, matching where the machine will be next cycle.
   always_comb begin
      pc_write_o   = ctrl.pcWrite;
      ir_write_o   = ctrl.irWrite;
      iord_o       = ctrl.iord;
      mem_read_o   = ctrl.memRead;
      mem_write_o  = ctrl.memWrite;
      reg_write_o  = ctrl.regWrite;
      mem_to_reg_o = ctrl.memToReg;
      alu_src_a_o  = ctrl.aluSrcA;
      alu_src_b_o  = ctrl.aluSrcB;
      alu_op_o     = ctrl.aluOp;
      pc_src_o     = ctrl.pcSrc;
      ctrl_r_o     = ctrl.ctrlR;
      illegal_o    = ctrl.illegal;
      state_o      = rst_i ? S_FETCH : stateReg;
      retired_o    = retiredReg;
   end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control unit for the RV32I-subset core: a Moore state machine that sequences one instruction over 3–5 cycles through fetch, decode, execute, memory and write-back. It sits beside the shared datapath (single ALU, unified memory port, register file, PC/IR registers) and drives that datapath's select and strobe lines. Memory accesses use a ready handshake. An illegal opcode traps the unit until reset. A retired-instruction counter is exposed for debug.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk_i  in  1  core clock
- rst_i  in  1  synchronous, active-high reset
- opcode_i  in  7  IR[6:0]; valid from DECODE onward
- zero_i  in  1  ALU compare result for branch
- mem_ready_i  in  1  memory completes access this cycle
- pc_write_o  out  1  load PC
- ir_write_o  out  1  load IR from memory read data
- iord_o  out  1  memory address select: 0 = PC, 1 = ALU result register
- mem_read_o  out  1  memory read request
- mem_write_o  out  1  memory write request
- reg_write_o  out  1  register-file write
- mem_to_reg_o  out  1  write-back select: 1 = memory data register
- alu_src_a_o  out  1  ALU A select: 0 = PC, 1 = rs1
- alu_src_b_o  out  2  ALU B select: 00 = rs2, 01 = const 4, 10 = immediate
- alu_op_o  out  3  000 add, 001 R, 010 I, 011 S, 100 L, 101 J, 110 B
- pc_src_o  out  2  PC source: 00 = ALU now, 01 = ALU result register (target)
- ctrl_r_o  out  1  funct7 qualifies ALU control; R-type only
- illegal_o  out  1  sticky trap flag
- state_o  out  4  current state encoding, for debug
- retired_o  out  CNT_W  count of completed instructions

## Operation
- States: FETCH, DECODE, EXEC_R, EXEC_I, ADDR, MEM_RD, MEM_WR, WB_ALU, WB_MEM, BRANCH, JUMP, TRAP.
- **FETCH:** mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00.
  - When mem_ready_i=1: ir_write=1, pc_write=1, then go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE:** alu_src_a=0, alu_src_b=10, alu_op=000; computes branch/jump target into the ALU result register.
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 → ADDR
    - 1100011 → BRANCH
    - 1101111 → JUMP
    - any other value → TRAP
- **EXEC_R:** alu_src_a=1, alu_src_b=00, alu_op=001, ctrl_r=1; then WB_ALU.
- **EXEC_I:** alu_src_a=1, alu_src_b=10, alu_op=010; then WB_ALU.
- **ADDR:** alu_src_a=1, alu_src_b=10, alu_op=100 for loads or 011 for stores; then MEM_RD (load) or MEM_WR (store).
- **MEM_RD:** mem_read=1, iord=1. Hold until mem_ready_i, then WB_MEM.
- **MEM_WR:** mem_write=1, iord=1. Hold until mem_ready_i, then FETCH; the instruction retires.
- **WB_ALU:** reg_write=1, mem_to_reg=0; then FETCH; retires.
- **WB_MEM:** reg_write=1, mem_to_reg=1; then FETCH; retires.
- **BRANCH:** alu_src_a=1, alu_src_b=00, alu_op=110, pc_src=01, pc_write=zero_i; then FETCH; retires.
- **JUMP:** pc_src=01, pc_write=1, alu_op=101; no register write; then FETCH; retires.
- **TRAP:** illegal_o=1 and all strobes 0. TRAP is absorbing until rst_i.
- Any strobe not listed for a state is 0.
- **retired_o:** increments by 1 on each retiring transition; wraps modulo 2^CNT_W.

## Timing
- Reset (sampled at a clk_i edge): state←FETCH, retired_o←0, illegal_o←0.
- While rst_i=1, every output strobe is forced to 0, and state_o reads the FETCH encoding.
- Outputs are combinational from the state register only. The exceptions are pc_write/ir_write in FETCH (qualified by mem_ready_i) and pc_write in BRANCH (qualified by zero_i).
- Latency with mem_ready_i held at 1:
  - R/I: 4 cycles
  - load: 5 cycles
  - store: 4 cycles
  - branch: 3 cycles
  - jump: 3 cycles
- Each cycle with mem_ready_i=0 in FETCH, MEM_RD or MEM_WR adds one cycle.
- The request stays asserted and the address select stays stable while waiting.
- mem_ready_i is ignored in all non-memory states.
- rst_i mid-instruction, including during a pending memory wait: the next state is FETCH and the pending request drops on the reset cycle. The counter clears; the aborted instruction does not retire.
- rst_i has priority over every transition and over the retire increment in the same cycle.

## Structure
- Package multicycle_pkg holds:
  - the 4-bit state encoding (FETCH=0 … TRAP=11)
  - the opcode constants (OP_R, OP_I, OP_S, OP_L, OP_J, OP_B)
  - the alu_op and alu_src_b/pc_src encodings, shared with the ALU control.
- One sub-module is natural: multicycle_outdec, a purely combinational state→strobe decoder. The top level holds the state register, next-state logic and counter.

## Test plan
- rst_i=1 for 2 cycles, then 0, mem_ready_i=1 → all strobes 0 during reset; the first cycle after reset is FETCH with mem_read=1, ir_write=1, pc_write=1; retired_o=0.
- Opcode 0110011 with mem_ready_i=1 → FETCH, DECODE, EXEC_R (ctrl_r=1, alu_op=001), WB_ALU (reg_write=1); retired_o goes 0→1 after cycle 4.
- Load (0000011) with mem_ready_i low for 3 cycles in MEM_RD → mem_read=1 and iord=1 held for 4 cycles, then WB_MEM with mem_to_reg=1; 8 cycles total.
- Branch (1100011): zero_i=1 → pc_write=1 and pc_src=01 in BRANCH; with zero_i=0 → pc_write=0; both cases retire in 3 cycles.
- Opcode 1111111 → TRAP after DECODE; illegal_o=1 persists for 20 cycles with all strobes 0; rst_i clears it.
- rst_i asserted during MEM_WR wait → mem_write drops that cycle; next state FETCH; retired_o=0. Also preload the counter to 2^CNT_W−1 → one retire wraps it to 0.
